pht_gshare: RTL and testbench
=============================

PHT_GSHARE -- requirements
Module: pht_gshare

Interface
REQ-001 SHALL have parameter CTR_WIDTH, default 2, meaning saturating-counter width in bits (>=1).
REQ-002 SHALL have parameter INDEX_WIDTH, default 8, meaning table index width, so DEPTH = 2**INDEX_WIDTH entries.
REQ-003 SHALL have parameter GHR_WIDTH, default 8, meaning global-history length; legal range 0..INDEX_WIDTH.
REQ-004 SHALL have parameter INIT_VALUE, default 2**(CTR_WIDTH-1)-1, meaning the weakly-not-taken value written to every entry at init.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port init_done  output  1  high once the init sweep completes.
REQ-008 SHALL have port pred_valid  input  1  prediction request.
REQ-009 SHALL have port pred_pc  input  32  branch PC.
REQ-010 SHALL have port pred_resp_valid  output  1  prediction result valid.
REQ-011 SHALL have port pred_taken  output  1  predicted direction, equal to the counter MSB.
REQ-012 SHALL have port pred_ctr  output  CTR_WIDTH  counter value read.
REQ-013 SHALL have port pred_index  output  INDEX_WIDTH  index used; the core returns it on update.
REQ-014 SHALL have port upd_valid  input  1  resolved-branch update.
REQ-015 SHALL have port upd_index  input  INDEX_WIDTH  entry to train.
REQ-016 SHALL have port upd_taken  input  1  resolved direction.
REQ-017 SHALL have port ghr  output  max(GHR_WIDTH,1)  current global history, newest outcome in bit 0.

Function
REQ-018 SHALL use FSM states INIT and READY; INIT goes to READY after the write to entry DEPTH-1, and READY is held until rst.
REQ-019 SHALL, in INIT, write INIT_VALUE to entry sweep_idx each cycle, starting at sweep_idx 0 and incrementing by 1, so the sweep takes DEPTH cycles.
REQ-020 SHALL, in INIT, ignore pred_valid and upd_valid, hold pred_resp_valid low and hold init_done low.
REQ-021 SHALL compute the index as pred_pc[INDEX_WIDTH+1:2] XOR zero-extended ghr.
REQ-022 SHALL give predictions a latency of 1 cycle: pred_valid in cycle N gives pred_resp_valid=1 in cycle N+1 with pred_index, pred_ctr and pred_taken; pred_resp_valid is low otherwise.
REQ-023 SHALL accept one prediction and one update per cycle, with no backpressure.
REQ-024 SHALL pipeline updates in two stages: U1 registers index and taken in cycle N, and U2 reads the entry, applies the saturating step and writes at the end of cycle N+1.
REQ-025 SHALL apply the saturating step as ctr+1 if taken and ctr-1 if not taken, clamped to 0..2**CTR_WIDTH-1.
REQ-026 SHALL, when a U2 write and a U2 read target the same index in the same cycle (back-to-back updates), forward the U2 write value so no update is lost.
REQ-027 SHALL, when a prediction read and a U2 write to the same index share a cycle, return the post-write value.
REQ-028 SHALL shift ghr as {ghr[GHR_WIDTH-2:0], upd_taken} in the cycle upd_valid is accepted in READY; with GHR_WIDTH=0, ghr SHALL read 0 and the index is PC bits only.
REQ-029 SHALL index the prediction with ghr as registered at the start of the request cycle, so same-cycle updates do not affect it.

Reset
REQ-030 SHALL, on rst, set state to INIT, sweep_idx 0, ghr 0, init_done 0, pred_resp_valid 0, pred_taken 0, pred_ctr 0, pred_index 0, and clear the U1/U2 valids.
REQ-031 SHALL, when rst is asserted mid-sweep or in READY, discard in-flight updates and restart the sweep at entry 0.
REQ-032 SHALL NOT reset the table contents directly; only the sweep initialises them.

Structure
REQ-033 SHALL place the FSM state enum, the saturating-step function and the index-hash function in the shared branch-predictor package.
REQ-034 SHALL instantiate one sub-module pht_array: a DEPTH x CTR_WIDTH flop array with 2 async read ports and 1 sync write port, with no reset.
REQ-035 SHALL multiplex the pht_array write port between the sweep in INIT and U2 in READY.

Verification
REQ-036 SHALL cover: rst for 1 cycle, then release -> init_done=0 for exactly 256 cycles and 1 in the next; a prediction on any pc then returns pred_ctr=01, pred_taken=0.
REQ-037 SHALL cover: ghr=0xA5, pred_pc=0x00000440 -> next cycle pred_index=0xB5.
REQ-038 SHALL cover: three back-to-back taken updates to index 0x12 from 01 -> entry reads 11, saturated, and a fourth taken update keeps 11.
REQ-039 SHALL cover: two not-taken updates to index 0x12 at 00 -> entry stays 00, and ghr low bits are 00.
REQ-040 SHALL cover: a prediction to 0x33 in the same cycle as the U2 write of 01->10 -> pred_ctr=10, pred_taken=1.
REQ-041 SHALL cover: rst at sweep_idx 0x40 with an update in flight -> sweep restarts at 0, the update is dropped, and init_done rises 256 cycles after release.

Source files
------------

// File: rtl/pht_gshare_pkg.sv
// Shared definitions for the gshare pattern-history-table predictor.
//
// Contents:
//   pht_state_e  - controller state: INIT (table sweep) and READY (serving).
//   sat_step     - one saturating up/down step of an N-bit counter.
//   gshare_hash  - word-aligned PC bits XOR global history, masked to the
//                  table index width.
//
// Both functions work on 32-bit containers with the real width passed in,
// so any instantiation can share them; callers size-cast the result.
package pht_gshare_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } pht_state_e;

  // Moves ctr one step toward taken (up) or not-taken (down), clamped to the
  // range of a width-bit unsigned counter.
  function automatic logic [31:0] sat_step(input logic [31:0] ctr,
                                           input logic        taken,
                                           input int unsigned width);
    logic [31:0] max_val;
    logic [31:0] result;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (taken) begin
      result = (ctr >= max_val) ? max_val : ctr + 32'd1;
    end else begin
      result = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
    return result;
  endfunction

  // Instructions are word aligned, so PC bits [1:0] carry no information and
  // the index starts at bit 2. History is already zero-extended by the caller.
  function automatic logic [31:0] gshare_hash(input logic [31:0] pc,
                                              input logic [31:0] hist,
                                              input int unsigned index_width);
    logic [31:0] mask;
    mask = (index_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << index_width) - 32'd1);
    return ((pc >> 2) ^ hist) & mask;
  endfunction

endpackage

// File: rtl/pht_gshare_array.sv
// pht_array: DEPTH x WIDTH flop-based counter storage.
//
// Ports:
//   clk        - write clock
//   wr_en      - write strobe; wr_data lands in wr_addr at the rising edge
//   wr_addr    - write address
//   wr_data    - write data
//   rd_a_addr  - read port A address (prediction lookup)
//   rd_a_data  - read port A data, combinational
//   rd_b_addr  - read port B address (update read-modify-write)
//   rd_b_data  - read port B data, combinational
//
// There is deliberately no reset: contents are only established by the
// controller's init sweep.
module pht_array #(
  parameter int WIDTH      = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr,
  output logic [WIDTH-1:0]      rd_a_data,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr,
  output logic [WIDTH-1:0]      rd_b_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/pht_gshare.sv
// pht_gshare: gshare branch direction predictor built on a table of
// saturating counters indexed by PC XOR global history.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   init_done         - high once every table entry has been initialised
//   pred_valid        - prediction request for pred_pc
//   pred_pc           - branch PC
//   pred_resp_valid   - one cycle after an accepted request
//   pred_taken        - MSB of the counter read
//   pred_ctr          - counter value read
//   pred_index        - table index used; the core hands it back on update
//   upd_valid         - resolved-branch update for upd_index
//   upd_index         - entry to train
//   upd_taken         - resolved direction, also shifted into ghr
//   ghr               - global history, newest outcome in bit 0
//
// After reset the controller sweeps INIT_VALUE into every entry, one per
// cycle, then serves one prediction and one update per cycle. Updates are a
// two-stage read-modify-write: U1 registers the request, U2 reads, steps and
// writes the counter in the following cycle.
module pht_gshare
  import pht_gshare_pkg::*;
#(
  parameter int CTR_WIDTH   = 2,
  parameter int INDEX_WIDTH = 8,
  parameter int GHR_WIDTH   = 8,
  parameter int INIT_VALUE  = 2 ** (CTR_WIDTH - 1) - 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     init_done,
  input  logic                                     pred_valid,
  input  logic [31:0]                              pred_pc,
  output logic                                     pred_resp_valid,
  output logic                                     pred_taken,
  output logic [CTR_WIDTH-1:0]                     pred_ctr,
  output logic [INDEX_WIDTH-1:0]                   pred_index,
  input  logic                                     upd_valid,
  input  logic [INDEX_WIDTH-1:0]                   upd_index,
  input  logic                                     upd_taken,
  output logic [((GHR_WIDTH > 0) ? GHR_WIDTH : 1)-1:0] ghr
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam int GW    = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
  localparam logic [CTR_WIDTH-1:0]   INIT_CTR  = CTR_WIDTH'(INIT_VALUE);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(DEPTH - 1);

  pht_state_e state;
  pht_state_e state_next;

  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic                   sweep_last;
  logic [GW-1:0]          ghr_q;
  logic                   ready;

  logic                   u1_valid;
  logic [INDEX_WIDTH-1:0] u1_index;
  logic                   u1_taken;
  logic                   u2_write;
  logic [CTR_WIDTH-1:0]   u2_new;

  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_addr;
  logic [CTR_WIDTH-1:0]   wr_data;
  logic [CTR_WIDTH-1:0]   rd_a_data;
  logic [CTR_WIDTH-1:0]   rd_b_data;

  logic [INDEX_WIDTH-1:0] pred_idx_c;
  logic [CTR_WIDTH-1:0]   pred_ctr_c;

  assign ready      = (state == READY);
  assign sweep_last = (sweep_idx == LAST_IDX);
  assign init_done  = ready;
  assign ghr        = ghr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // INIT leaves only after the last entry has been written; READY is
  // terminal until the next reset.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_last) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // Sweep pointer; it wraps to zero as the FSM enters READY, so a later
  // reset always restarts from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_idx <= '0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
    end
  end

  // Global history. The shift-and-OR form works for any width >= 1; with
  // no history configured the register simply stays at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if ((GHR_WIDTH > 0) && ready && upd_valid) begin
      ghr_q <= (ghr_q << 1) | GW'(upd_taken);
    end
  end

  // U1: capture the update request. Only the valid bit needs clearing; the
  // payload is ignored whenever the valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      u1_valid <= 1'b0;
    end else begin
      u1_valid <= upd_valid && ready;
      u1_index <= upd_index;
      u1_taken <= upd_taken;
    end
  end

  // U2: read-modify-write of the captured entry. Reads are combinational
  // from flops and the write commits at the end of the same cycle, so an
  // update issued the very next cycle already sees this value through the
  // array itself -- back-to-back updates to one entry need no extra bypass.
  assign u2_new   = CTR_WIDTH'(sat_step(32'(rd_b_data), u1_taken, CTR_WIDTH));
  assign u2_write = u1_valid && ready && !rst;

  // Single write port: the sweep owns it in INIT, U2 in READY. Reset
  // suppresses any write so an update caught in flight is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sweep_idx;
    wr_data = INIT_CTR;
    if (!rst) begin
      if (state == INIT) begin
        wr_en = 1'b1;
      end else if (u2_write) begin
        wr_en   = 1'b1;
        wr_addr = u1_index;
        wr_data = u2_new;
      end
    end
  end

  pht_array #(
    .WIDTH      (CTR_WIDTH),
    .ADDR_WIDTH (INDEX_WIDTH)
  ) u_array (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_a_addr (pred_idx_c),
    .rd_a_data (rd_a_data),
    .rd_b_addr (u1_index),
    .rd_b_data (rd_b_data)
  );

  // Prediction lookup uses the history registered at the start of this
  // cycle. If U2 is writing the same entry right now, the array still holds
  // the stale value, so the freshly stepped counter is returned instead.
  assign pred_idx_c = INDEX_WIDTH'(gshare_hash(pred_pc, 32'(ghr_q), INDEX_WIDTH));
  assign pred_ctr_c = (u2_write && (u1_index == pred_idx_c)) ? u2_new : rd_a_data;

  // Prediction response register: one-cycle latency, held between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_ctr        <= '0;
      pred_index      <= '0;
    end else begin
      pred_resp_valid <= pred_valid && ready;
      if (pred_valid && ready) begin
        pred_index <= pred_idx_c;
        pred_ctr   <= pred_ctr_c;
        pred_taken <= pred_ctr_c[CTR_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pht_gshare.sv
// Directed self-checking bench for pht_gshare with default parameters
// (2-bit counters, 256 entries, 8-bit history). Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the rising edge where the design updates.
module tb_pht_gshare;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_resp_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic [7:0]  pred_index;
  logic        upd_valid;
  logic [7:0]  upd_index;
  logic        upd_taken;
  logic [7:0]  ghr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_ghr;
  logic [7:0] pattern;
  int         low_cycles;
  logic       resp_seen;
  logic       ghr_moved;

  pht_gshare dut (
    .clk             (clk),
    .rst             (rst),
    .init_done       (init_done),
    .pred_valid      (pred_valid),
    .pred_pc         (pred_pc),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .pred_ctr        (pred_ctr),
    .pred_index      (pred_index),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .ghr             (ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle, landing on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic        pv,
                               input logic [31:0] pc,
                               input logic        uv,
                               input logic [7:0]  ui,
                               input logic        ut);
    pred_valid = pv;
    pred_pc    = pc;
    upd_valid  = uv;
    upd_index  = ui;
    upd_taken  = ut;
  endtask

  // PC that hashes to the wanted entry under the history the design holds.
  function automatic logic [31:0] pc_for(input logic [7:0] idx, input logic [7:0] h);
    return {22'd0, idx ^ h, 2'b00};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    exp_ghr = 8'h00;
    tick();

    // ---- Reset values ----
    checks++; assert (init_done === 1'b0) else begin failures++; $error("[TB] FAIL rst_init_done observed=%0b required=0", init_done); end
    checks++; assert (pred_resp_valid === 1'b0) else begin failures++; $error("[TB] FAIL rst_resp_valid observed=%0b required=0", pred_resp_valid); end
    checks++; assert (pred_ctr === 2'b00) else begin failures++; $error("[TB] FAIL rst_pred_ctr observed=%0b required=00", pred_ctr); end
    checks++; assert (pred_index === 8'h00) else begin failures++; $error("[TB] FAIL rst_pred_index observed=%0h required=00", pred_index); end
    checks++; assert (ghr === 8'h00) else begin failures++; $error("[TB] FAIL rst_ghr observed=%0h required=00", ghr); end
    rst = 1'b0;

    // ---- Init sweep: requests during INIT must be ignored ----
    applyStimulus(1'b1, 32'h0000_0ABC, 1'b1, 8'h12, 1'b1);
    low_cycles = 0; resp_seen = 1'b0; ghr_moved = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (init_done === 1'b1) break;
      low_cycles++;
      if (pred_resp_valid !== 1'b0) resp_seen = 1'b1;
      if (ghr !== 8'h00) ghr_moved = 1'b1;
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (low_cycles === 256) else begin failures++; $error("[TB] FAIL sweep_len observed=%0d required=256", low_cycles); end
    checks++; assert (init_done === 1'b1) else begin failures++; $error("[TB] FAIL init_done_rise observed=%0b required=1", init_done); end
    checks++; assert (resp_seen === 1'b0) else begin failures++; $error("[TB] FAIL init_resp_ignored observed=%0b required=0", resp_seen); end
    checks++; assert (ghr_moved === 1'b0) else begin failures++; $error("[TB] FAIL init_upd_ignored observed=%0b required=0", ghr_moved); end
    checks++; assert (pred_resp_valid === 1'b0) else begin failures++; $error("[TB] FAIL init_last_req observed=%0b required=0", pred_resp_valid); end

    // ---- First prediction after init: weakly not-taken ----
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_resp_valid === 1'b1) else begin failures++; $error("[TB] FAIL first_resp_valid observed=%0b required=1", pred_resp_valid); end
    checks++; assert (pred_ctr === 2'b01) else begin failures++; $error("[TB] FAIL first_ctr observed=%0b required=01", pred_ctr); end
    checks++; assert (pred_taken === 1'b0) else begin failures++; $error("[TB] FAIL first_taken observed=%0b required=0", pred_taken); end
    checks++; assert (pred_index === 8'h00) else begin failures++; $error("[TB] FAIL first_index observed=%0h required=00", pred_index); end
    tick();
    checks++; assert (pred_resp_valid === 1'b0) else begin failures++; $error("[TB] FAIL resp_one_cycle observed=%0b required=0", pred_resp_valid); end

    // ---- Build ghr = 0xA5 with back-to-back updates to entry 0x80 ----
    pattern = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 8'h80, pattern[i]);
      exp_ghr = {exp_ghr[6:0], pattern[i]};
      tick();
    end
    checks++; assert (ghr === 8'hA5) else begin failures++; $error("[TB] FAIL ghr_a5 observed=%0h required=a5", ghr); end

    // Prediction uses the start-of-cycle history even with a same-cycle update.
    applyStimulus(1'b1, 32'h0000_0440, 1'b1, 8'h80, 1'b1);
    exp_ghr = {exp_ghr[6:0], 1'b1};
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_index === 8'hB5) else begin failures++; $error("[TB] FAIL hash_index observed=%0h required=b5", pred_index); end
    checks++; assert (pred_ctr === 2'b01) else begin failures++; $error("[TB] FAIL hash_ctr observed=%0b required=01", pred_ctr); end
    checks++; assert (ghr === 8'h4B) else begin failures++; $error("[TB] FAIL ghr_shift observed=%0h required=4b", ghr); end

    // ---- Three taken updates to 0x12 saturate at 11 ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 8'h12, 1'b1);
      exp_ghr = {exp_ghr[6:0], 1'b1};
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, pc_for(8'h12, exp_ghr), 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_index === 8'h12) else begin failures++; $error("[TB] FAIL sat_index observed=%0h required=12", pred_index); end
    checks++; assert (pred_ctr === 2'b11) else begin failures++; $error("[TB] FAIL sat_up_ctr observed=%0b required=11", pred_ctr); end
    checks++; assert (pred_taken === 1'b1) else begin failures++; $error("[TB] FAIL sat_up_taken observed=%0b required=1", pred_taken); end

    // Fourth taken update must hold at 11.
    applyStimulus(1'b0, 32'd0, 1'b1, 8'h12, 1'b1);
    exp_ghr = {exp_ghr[6:0], 1'b1};
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, pc_for(8'h12, exp_ghr), 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_ctr === 2'b11) else begin failures++; $error("[TB] FAIL sat_hold_ctr observed=%0b required=11", pred_ctr); end

    // ---- Five not-taken: 11->10->01->00, then two more stay at 00 ----
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 8'h12, 1'b0);
      exp_ghr = {exp_ghr[6:0], 1'b0};
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    tick();
    checks++; assert (ghr[1:0] === 2'b00) else begin failures++; $error("[TB] FAIL ghr_low_nt observed=%0b required=00", ghr[1:0]); end
    applyStimulus(1'b1, pc_for(8'h12, exp_ghr), 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_ctr === 2'b00) else begin failures++; $error("[TB] FAIL sat_down_ctr observed=%0b required=00", pred_ctr); end
    checks++; assert (pred_taken === 1'b0) else begin failures++; $error("[TB] FAIL sat_down_taken observed=%0b required=0", pred_taken); end

    // ---- Prediction in the same cycle as the U2 write of 0x33 (01->10) ----
    applyStimulus(1'b0, 32'd0, 1'b1, 8'h33, 1'b1);
    exp_ghr = {exp_ghr[6:0], 1'b1};
    tick();
    applyStimulus(1'b1, pc_for(8'h33, exp_ghr), 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_index === 8'h33) else begin failures++; $error("[TB] FAIL fwd_index observed=%0h required=33", pred_index); end
    checks++; assert (pred_ctr === 2'b10) else begin failures++; $error("[TB] FAIL fwd_ctr observed=%0b required=10", pred_ctr); end
    checks++; assert (pred_taken === 1'b1) else begin failures++; $error("[TB] FAIL fwd_taken observed=%0b required=1", pred_taken); end

    // ---- Reset in READY with an update in U1 ----
    applyStimulus(1'b0, 32'd0, 1'b1, 8'h33, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; assert (init_done === 1'b0) else begin failures++; $error("[TB] FAIL rst2_init_done observed=%0b required=0", init_done); end
    checks++; assert (ghr === 8'h00) else begin failures++; $error("[TB] FAIL rst2_ghr observed=%0h required=00", ghr); end
    checks++; assert (pred_ctr === 2'b00) else begin failures++; $error("[TB] FAIL rst2_pred_ctr observed=%0b required=00", pred_ctr); end

    // ---- Reset again at sweep_idx 0x40 with an update presented ----
    for (int i = 0; i < 64; i++) tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 8'h33, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    low_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (init_done === 1'b1) break;
      low_cycles++;
      tick();
    end
    checks++; assert (low_cycles === 256) else begin failures++; $error("[TB] FAIL restart_len observed=%0d required=256", low_cycles); end
    checks++; assert (ghr === 8'h00) else begin failures++; $error("[TB] FAIL restart_ghr observed=%0h required=00", ghr); end

    // Entries trained before reset are back to weakly not-taken.
    applyStimulus(1'b1, pc_for(8'h33, 8'h00), 1'b0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, pc_for(8'h12, 8'h00), 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_ctr === 2'b01) else begin failures++; $error("[TB] FAIL restart_ctr33 observed=%0b required=01", pred_ctr); end
    checks++; assert (pred_index === 8'h33) else begin failures++; $error("[TB] FAIL restart_idx33 observed=%0h required=33", pred_index); end
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    checks++; assert (pred_ctr === 2'b01) else begin failures++; $error("[TB] FAIL restart_ctr12 observed=%0b required=01", pred_ctr); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
